// File: rtl/pc_redirect_unit.sv
// Program-counter owner for the fetch stage. Redirects fetch on EX-stage branch/jump-register
// decisions, flushes IF/ID and ID/EX, parks a redirect behind an outstanding fetch, traps misaligned targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] ex_pc_plus4,
    input  logic [31:0] ex_imm,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_target_reg, pend_target_next;
    logic        misalign_err_reg, misalign_err_next;

    logic        redir;
    logic [31:0] raw_target;
    logic        target_misaligned;
    logic [31:0] eff_target;

    // Branch wins over jump-register when both are raised in the same cycle.
    assign redir             = branch_taken | jr_taken;
    assign raw_target        = branch_taken ? (ex_pc_plus4 + {ex_imm[29:0], 2'b00}) : jr_target;
    assign target_misaligned = (raw_target[1:0] != 2'b00);
    assign eff_target        = target_misaligned ? TRAP_VEC : raw_target;

    assign imem_addr    = pc_reg;
    assign pc_plus4     = pc_reg + 32'd4;
    assign misalign_err = misalign_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_PC;
            pend_target_reg  <= 32'h0000_0000;
            misalign_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            pend_target_reg  <= pend_target_next;
            misalign_err_reg <= misalign_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        pend_target_next  = pend_target_reg;
        misalign_err_next = misalign_err_reg;
        imem_req          = 1'b0;
        if_valid          = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_flush       = 1'b0;

        unique case (state_reg)
            BOOT: begin
                state_next = RUN;
                pc_next    = RESET_PC;
            end
            RUN: begin
                imem_req    = 1'b1;
                if_id_flush = redir;
                id_ex_flush = redir;
                if (redir) begin
                    misalign_err_next = misalign_err_reg | target_misaligned;
                    if (imem_ready) begin
                        pc_next = eff_target;
                    end else begin
                        // Fetch still in flight: address must hold, so park the target.
                        pend_target_next = eff_target;
                        state_next       = KILL;
                    end
                end else if (imem_ready && !stall) begin
                    pc_next  = pc_reg + 32'd4;
                    if_valid = 1'b1;
                end
            end
            KILL: begin
                imem_req    = 1'b1;
                if_id_flush = redir;
                id_ex_flush = redir;
                if (redir) begin
                    misalign_err_next = misalign_err_reg | target_misaligned;
                    pend_target_next  = eff_target;
                end
                // The wrong-path fetch finishing here is simply dropped (if_valid stays 0).
                if (imem_ready) begin
                    pc_next    = redir ? eff_target : pend_target_reg;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized bench for pc_redirect_unit against a transaction-level model of the fetch PC
// (boot flag, optional pending-redirect queue, sticky trap flag).
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] ex_pc_plus4 = '0;
    logic [31:0] ex_imm = '0;
    logic        jr_taken = 1'b0;
    logic [31:0] jr_target = '0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    // Reference model
    bit          m_booting;
    logic [31:0] m_pc;
    bit          m_err;
    logic [31:0] m_pending[$];

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC(RESET_PC),
        .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .ex_pc_plus4(ex_pc_plus4),
        .ex_imm(ex_imm),
        .jr_taken(jr_taken),
        .jr_target(jr_target),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .pc_plus4(pc_plus4),
        .if_valid(if_valid),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .misalign_err(misalign_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_pc      = RESET_PC;
        m_err     = 1'b0;
        m_pending.delete();
    endtask

    // Assert reset mid-cycle, check the reset outputs immediately, release after the next edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_valid", {31'b0, if_valid}, 32'h0);
        check_eq("rst_flush", {30'b0, if_id_flush, id_ex_flush}, 32'h0);
        check_eq("rst_err", {31'b0, misalign_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check combinational outputs against the model, advance the model.
    task automatic step(input logic br, input logic [31:0] p4, input logic [31:0] imm,
                        input logic jr, input logic [31:0] jt, input logic rdy, input logic stl);
        logic        redir;
        logic [31:0] tgt;
        logic        exp_valid;
        @(negedge clk);
        branch_taken = br;
        ex_pc_plus4  = p4;
        ex_imm       = imm;
        jr_taken     = jr;
        jr_target    = jt;
        imem_ready   = rdy;
        stall        = stl;
        #1;
        txn++;
        redir     = (br || jr) && !m_booting;
        exp_valid = !m_booting && !redir && (m_pending.size() == 0) && rdy && !stl;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, !m_booting});
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
        check_eq("if_id_flush", {31'b0, if_id_flush}, {31'b0, redir});
        check_eq("id_ex_flush", {31'b0, id_ex_flush}, {31'b0, redir});
        check_eq("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        $display("txn %0d br=%0b jr=%0b rdy=%0b stall=%0b addr=0x%08h valid=%0b flush=%0b err=%0b",
                 txn, br, jr, rdy, stl, imem_addr, if_valid, if_id_flush, misalign_err);
        @(posedge clk);
        if (m_booting) begin
            m_booting = 1'b0;
            m_pc      = RESET_PC;
        end else if (redir) begin
            tgt = br ? p4 + imm * 32'd4 : jt;
            if (tgt % 4 != 0) begin
                tgt   = TRAP_VEC;
                m_err = 1'b1;
            end
            m_pending.delete();
            if (rdy) m_pc = tgt;
            else     m_pending.push_back(tgt);
        end else if (m_pending.size() != 0) begin
            if (rdy) m_pc = m_pending.pop_front();
        end else if (rdy && !stl) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] jt;
        logic [31:0] p4;
        logic [31:0] imm;
        logic        br;
        logic        jr;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Boot then sequential fetch 0x0, 0x4, 0x8, 0xC
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
        // Branch at pc=0x10: 0x0C + (4<<2) = 0x1C
        step(1, 32'h0000_000C, 32'h0000_0004, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Branch behind an outstanding fetch: 0x40 - 4 = 0x3C after KILL drains
        step(1, 32'h0000_0040, 32'hFFFF_FFFF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        // Jump to 0x20, stall three cycles, release
        step(0, 0, 0, 1, 32'h0000_0020, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Misaligned jump traps to TRAP_VEC; flag stays sticky through a good redirect
        step(0, 0, 0, 1, 32'h0000_1002, 1, 0);
        step(0, 0, 0, 1, 32'h0000_0100, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Branch and jump together: branch wins
        step(1, 32'h0000_0200, 32'h0000_0001, 1, 32'h0000_0300, 1, 0);
        // PC wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Reset while a redirect is pending
        step(0, 0, 0, 1, 32'h0000_0400, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            r   = $urandom();
            br  = (r[3:0] == 4'd0);
            jr  = (r[7:4] == 4'd0);
            p4  = $urandom() & 32'hFFFF_FFFC;
            imm = (r[10:8] == 3'd0) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32;
            jt  = $urandom();
            if (r[13:11] != 3'd0) jt = jt & 32'hFFFF_FFFC;
            step(br, p4, imm, jr, jt, r[17:16] != 2'b00, r[20:18] == 3'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and drives the instruction-memory fetch handshake.
- Consumes the EX-stage branch decision (branch_taken) and jump-register requests, and redirects fetch to the resolved target.
- Generates same-cycle flushes for the IF/ID and ID/EX pipeline registers.
- Buffers a redirect that arrives while a fetch is outstanding, and traps misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
TRAP_VEC, 32'h0000_0080, fetch address used when a redirect target is misaligned

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hazard-unit stall; holds PC
branch_taken  input  1  EX-stage branch resolution
ex_pc_plus4  input  32  PC+4 of the branch in EX
ex_imm  input  32  sign-extended word offset of the branch in EX
jr_taken  input  1  EX-stage jump-register request
jr_target  input  32  register-sourced jump target
imem_ready  input  1  fetch at imem_addr completes this cycle
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc)
pc_plus4  output  32  pc + 4, for the IF/ID register
if_valid  output  1  the instruction returned this cycle is to be written into IF/ID
if_id_flush  output  1  bubble the IF/ID register
id_ex_flush  output  1  bubble the ID/EX register
misalign_err  output  1  sticky misaligned-target flag

Behaviour:
- Reset is asynchronous and active-low on rst_n, in a single clk domain.
- While rst_n=0:
  - state=BOOT, pc=RESET_PC, pend_target=0, misalign_err=0.
  - Outputs: imem_req=0, if_valid=0, both flushes=0.
- Redirect request: redir = branch_taken | jr_taken.
- Target selection:
  - If branch_taken=1, tgt = ex_pc_plus4 + (ex_imm<<2), modulo 2^32 (wraps, no overflow flag). branch_taken wins when both requests are asserted.
  - Otherwise tgt = jr_target.
- Misalignment: if tgt[1:0]≠0, the effective target is TRAP_VEC and misalign_err is set on that edge. misalign_err is cleared only by reset.
- imem_addr=pc at all times. pc_plus4=pc+4, with wrap.
- Flushes: if_id_flush = id_ex_flush = redir, combinational, in RUN and KILL. In BOOT both flushes are forced to 0.
- Handshake rules:
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - pc changes only on an edge where imem_ready=1, or in BOOT.
- FSM states: BOOT, RUN, KILL.
- BOOT:
  - imem_req=0; redir and stall are ignored.
  - Next cycle: RUN, with pc=RESET_PC.
- RUN (imem_req=1):
  - redir & imem_ready: pc<=effective target; if_valid=0; stay in RUN.
  - redir & !imem_ready: pend_target<=effective target; go to KILL; pc unchanged.
  - !redir & imem_ready & !stall: pc<=pc+4; if_valid=1.
  - !redir & imem_ready & stall: pc held; if_valid=0; the same address is refetched.
  - !redir & !imem_ready: hold; if_valid=0.
- KILL (imem_req=1, if_valid=0):
  - The outstanding wrong-path fetch completes and is discarded.
  - When imem_ready=1: pc<=pend_target and go to RUN.
  - stall is ignored in KILL.
  - A new redir in KILL overwrites pend_target (last wins) and re-asserts the flushes.
- Priority: redir > stall.
- Reset mid-KILL: the pending target is discarded and the unit restarts at BOOT/RESET_PC.
- Latency: a redirect seen with imem_ready=1 puts the new address on imem_addr in the next cycle.

Test Plan:
- Reset, then imem_ready held at 1, no stall -> imem_req=0 for one cycle, then imem_addr=0x0, 0x4, 0x8 on successive cycles, if_valid=1 on each.
- pc=0x10, branch_taken=1, ex_pc_plus4=0x0C, ex_imm=0x4, imem_ready=1 -> both flushes=1 that cycle, if_valid=0, next imem_addr=0x1C.
- branch_taken with imem_ready=0, ex_pc_plus4=0x40, ex_imm=0xFFFF_FFFF -> state KILL, imem_addr held. Then 2 cycles later imem_ready=1 -> if_valid=0, next imem_addr=0x3C.
- stall=1 for 3 cycles at pc=0x20 with imem_ready=1 -> imem_addr stays 0x20 and if_valid=0. Release stall -> if_valid=1, next imem_addr=0x24.
- jr_taken=1, jr_target=0x0000_1002, imem_ready=1 -> next imem_addr=0x80, misalign_err=1 and stays 1 through later valid redirects until rst_n=0.
- Wrap and reset cases:
  - pc=0xFFFF_FFFC, imem_ready=1 -> pc_plus4=0x0, next imem_addr=0x0.
  - rst_n pulsed low while in KILL -> imem_req=0 immediately, restart at 0x0.
